mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 278 +++++++++++++++++++++++++++
 tb/tb_mem_access.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access -- MEM pipeline stage: data-bus load/store sequencer + writeback reg
//
// Takes one EX/MEM record per IDLE cycle. Non-memory ops pass to the writeback
// register with one cycle of latency. Loads and stores (LB, LBU, LW, SB, SW)
// issue a single data-bus request. The pipeline is held via stallreq until
// bus_ack arrives, and then the load result (or a store bubble) is written back.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, a BUSY phase that sees no bus_ack for TIMEOUT_CYC cycles is
//   aborted: bus_req drops, bus_err pulses for one cycle and no register is
//   written. When undefined, BUSY waits indefinitely and bus_err is tied low.
//
// Parameters
//   TIMEOUT_CYC  bus cycles allowed before abort (only with MEM_TIMEOUT_EN)
//
// Ports
//   clk, rst                         clock (rising edge), async active-low reset
//   mem_wd/mem_wreg/mem_wdata        destination, write enable, ALU result
//   mem_op/mem_addr/mem_sdata        memory opcode, byte address, store data
//   bus_req/we/addr/sel/wdata (out)  registered data-bus request
//   bus_ack/bus_rdata (in)           data-bus completion and read word
//   wb_wd/wb_wreg/wb_wdata (out)     registered writeback to the register file
//   stallreq (out)                   combinational pipeline hold
//   bus_err (out)                    one-cycle abort pulse (timeout build only)
// -----------------------------------------------------------------------------
module mem_access #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stallreq,
  output logic        bus_err
);

  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LW  = 3'b011;
  localparam logic [2:0] OP_SB  = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;

  // A zero timeout would abort every transaction before it could complete.
  if (TIMEOUT_CYC == 0) begin : g_cfg_check
    $error("mem_access: TIMEOUT_CYC must be nonzero");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // True for the five opcodes that touch the data bus; every other code is a no-op.
  function automatic logic is_mem_op(input logic [2:0] op);
    logic r;
    case (op)
      OP_LB, OP_LBU, OP_LW, OP_SB, OP_SW: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // Little-endian byte-lane enables; word ops ignore the low address bits.
  function automatic logic [3:0] lane_sel(input logic [2:0] op, input logic [1:0] lo);
    logic [3:0] r;
    case (op)
      OP_LW, OP_SW: r = 4'b1111;
      default:      r = 4'b0001 << lo;
    endcase
    return r;
  endfunction

  // Byte stores replicate the byte on every lane so any lane the slave picks is valid.
  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] sdata);
    logic [31:0] r;
    case (op)
      OP_SB:   r = {4{sdata[7:0]}};
      OP_SW:   r = sdata;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Extracts the addressed byte and extends it (signed for LB, unsigned for LBU).
  function automatic logic [31:0] load_data(input logic [2:0] op, input logic [1:0] lo,
                                            input logic [31:0] rdata);
    logic [7:0]  b;
    logic [31:0] r;
    case (lo)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      2'd3:    b = rdata[31:24];
      default: b = 8'h00;
    endcase
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'h00_0000, b};
      OP_LW:   r = rdata;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [4:0]  wb_wd_q, wb_wd_d;
  logic        wb_wreg_q, wb_wreg_d;
  logic [31:0] wb_wdata_q, wb_wdata_d;

  logic        is_mem_s;
  logic        is_store_s;

  assign is_mem_s   = is_mem_op(mem_op);
  assign is_store_s = (mem_op == OP_SB) || (mem_op == OP_SW);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  // Count value during the last allowed BUSY cycle.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             bus_err_q, bus_err_d;
  logic             tmo_hit_s;

  // Abort fires in the last allowed BUSY cycle only if the ack has not arrived.
  assign tmo_hit_s = (state_q == ST_BUSY) && !bus_ack && (tmo_cnt_q == TMO_LAST);
  assign bus_err   = bus_err_q;
`else
  assign bus_err   = 1'b0;
`endif

  // Pipeline hold: raised as soon as a memory op is seen, released in the
  // cycle the transaction ends (ack or abort) so upstream advances on that edge.
  always_comb begin
    stallreq = 1'b0;
    case (state_q)
      ST_IDLE: stallreq = is_mem_s;
`ifdef MEM_TIMEOUT_EN
      ST_BUSY: stallreq = !bus_ack && !tmo_hit_s;
`else
      ST_BUSY: stallreq = !bus_ack;
`endif
      default: stallreq = 1'b0;
    endcase
  end

  // Next-state and next-output computation for the IDLE/BUSY sequencer.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    wb_wd_d     = wb_wd_q;
    wb_wreg_d   = wb_wreg_q;
    wb_wdata_d  = wb_wdata_q;
`ifdef MEM_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    bus_err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (is_mem_s) begin
          state_d     = ST_BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = is_store_s;
          bus_addr_d  = {mem_addr[31:2], 2'b00};
          bus_sel_d   = lane_sel(mem_op, mem_addr[1:0]);
          bus_wdata_d = store_data(mem_op, mem_sdata);
          // Bubble while the bus transaction is outstanding.
          wb_wreg_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
          tmo_cnt_d   = {CNT_W{1'b0}};
`endif
        end else begin
          bus_req_d   = 1'b0;
          wb_wd_d     = mem_wd;
          wb_wreg_d   = mem_wreg;
          wb_wdata_d  = mem_wdata;
        end
      end
      ST_BUSY: begin
        if (bus_ack) begin
          state_d    = ST_IDLE;
          bus_req_d  = 1'b0;
          wb_wd_d    = mem_wd;
          if (is_store_s) begin
            wb_wreg_d  = 1'b0;
            wb_wdata_d = mem_wdata;
          end else begin
            wb_wreg_d  = mem_wreg;
            wb_wdata_d = load_data(mem_op, mem_addr[1:0], bus_rdata);
          end
`ifdef MEM_TIMEOUT_EN
        end else if (tmo_hit_s) begin
          state_d    = ST_IDLE;
          bus_req_d  = 1'b0;
          bus_err_d  = 1'b1;
          wb_wreg_d  = 1'b0;
        end else begin
          tmo_cnt_d  = tmo_cnt_q + CNT_W'(1);
`else
        end else begin
          state_d    = ST_BUSY;
`endif
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0000_0000;
      bus_sel_q   <= 4'b0000;
      bus_wdata_q <= 32'h0000_0000;
      wb_wd_q     <= 5'd0;
      wb_wreg_q   <= 1'b0;
      wb_wdata_q  <= 32'h0000_0000;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_q   <= {CNT_W{1'b0}};
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      wb_wd_q     <= wb_wd_d;
      wb_wreg_q   <= wb_wreg_d;
      wb_wdata_q  <= wb_wdata_d;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_sel   = bus_sel_q;
  assign bus_wdata = bus_wdata_q;
  assign wb_wd     = wb_wd_q;
  assign wb_wreg   = wb_wreg_q;
  assign wb_wdata  = wb_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: table of vectors plus hand-written
// sequences for idle acks, reset mid-transaction and (when MEM_TIMEOUT_EN is
// defined) the abort path. Writeback expectations go through a FIFO scoreboard.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  mem_wd = 5'd0;
  logic        mem_wreg = 1'b0;
  logic [31:0] mem_wdata = 32'h0;
  logic [2:0]  mem_op = 3'b000;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_sdata = 32'h0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        stallreq, bus_err;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .stallreq(stallreq), .bus_err(bus_err)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  dly;      // BUSY cycles without ack before the ack cycle
    logic [31:0] xaddr;
    logic [3:0]  xsel;
    logic        xwe;
    logic [31:0] xbwdata;
    logic        xwreg;
    logic [31:0] xwdata;
  } vec_t;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        chk_data;
  } wb_t;

  vec_t vt [10];
  vec_t tv;
  wb_t  exp_q [$];
  int   checks = 0;
  int   errors = 0;
  bit   pend = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit tb_is_mem(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd5);
  endfunction

  // Compare the oldest outstanding writeback once its completion edge has passed.
  task automatic sb_drain();
    wb_t e;
    if (pend) begin
      pend = 1'b0;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got empty queue expected one entry");
      end else begin
        e = exp_q.pop_front();
        chk("wb_wd", {59'd0, wb_wd}, {59'd0, e.wd});
        chk("wb_wreg", {63'd0, wb_wreg}, {63'd0, e.wreg});
        if (e.chk_data) chk("wb_wdata", {32'd0, wb_wdata}, {32'd0, e.wdata});
        chk("bus_idle", {63'd0, bus_req}, 64'd0);
        chk("err_idle", {63'd0, bus_err}, 64'd0);
      end
    end
  endtask

  // Called just after a rising edge; returns just after the completing edge.
  task automatic run_vec(input vec_t v);
    int stalls;
    mem_op = v.op; mem_addr = v.addr; mem_sdata = v.sdata;
    mem_wd = v.wd; mem_wreg = v.wreg; mem_wdata = v.wdata;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    exp_q.push_back('{v.wd, v.xwreg, v.xwdata, !v.xwe});
    @(negedge clk);
    sb_drain();
    stalls = stallreq ? 1 : 0;
    if (!tb_is_mem(v.op)) begin
      chk("stall_none", {63'd0, stallreq}, 64'd0);
      chk("req_none", {63'd0, bus_req}, 64'd0);
      @(posedge clk); #1;
    end else begin
      chk("stall_idle", {63'd0, stallreq}, 64'd1);
      @(posedge clk); #1;
      for (int c = 0; c <= int'(v.dly); c++) begin
        bus_ack   = (c == int'(v.dly));
        bus_rdata = (c == int'(v.dly)) ? v.rdata : $urandom();
        @(negedge clk);
        chk("bus_fields", {26'd0, bus_req, bus_we, bus_addr, bus_sel},
            {26'd0, 1'b1, v.xwe, v.xaddr, v.xsel});
        if (v.xwe) chk("bus_wdata", {32'd0, bus_wdata}, {32'd0, v.xbwdata});
        chk("bubble", {63'd0, wb_wreg}, 64'd0);
        chk("err_busy", {63'd0, bus_err}, 64'd0);
        if (stallreq) stalls++;
        @(posedge clk); #1;
      end
      bus_ack = 1'b0;
      chk("stall_cycles", 64'(stalls), 64'(int'(v.dly) + 1));
    end
    pend = 1'b1;
  endtask

  // Park the inputs on a zero no-op and drain any pending writeback.
  task automatic flush();
    mem_op = 3'b000; mem_wd = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'h0;
    mem_addr = 32'h0; mem_sdata = 32'h0; bus_ack = 1'b0;
    @(negedge clk);
    sb_drain();
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_bus"}, {26'd0, bus_req, bus_we, bus_addr, bus_sel}, 64'd0);
    chk({name, "_wb"}, {26'd0, bus_wdata, wb_wd, wb_wreg}, 64'd0);
    chk({name, "_misc"}, {30'd0, wb_wdata, bus_err, stallreq}, 64'd0);
  endtask

  initial begin
    vt[0] = '{3'b000, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0000_1234, 32'h0, 4'd0,
              32'h0, 4'b0000, 1'b0, 32'h0, 1'b1, 32'h0000_1234};
    vt[1] = '{3'b001, 32'h0000_1003, 32'h0, 5'd7, 1'b1, 32'h0000_1003, 32'h80FF_FF00, 4'd3,
              32'h0000_1000, 4'b1000, 1'b0, 32'h0, 1'b1, 32'hFFFF_FF80};
    vt[2] = '{3'b010, 32'h0000_1002, 32'h0, 5'd8, 1'b1, 32'h0, 32'h12A5_5678, 4'd0,
              32'h0000_1000, 4'b0100, 1'b0, 32'h0, 1'b1, 32'h0000_00A5};
    vt[3] = '{3'b001, 32'h0000_2000, 32'h0, 5'd9, 1'b1, 32'h0, 32'hDEAD_BE7F, 4'd1,
              32'h0000_2000, 4'b0001, 1'b0, 32'h0, 1'b1, 32'h0000_007F};
    vt[4] = '{3'b011, 32'h0000_3006, 32'h0, 5'd31, 1'b1, 32'h0, 32'hCAFE_F00D, 4'd2,
              32'h0000_3004, 4'b1111, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D};
    vt[5] = '{3'b100, 32'h0000_2001, 32'h1234_56AB, 5'd10, 1'b1, 32'h0000_2001, 32'h0, 4'd1,
              32'h0000_2000, 4'b0010, 1'b1, 32'hABAB_ABAB, 1'b0, 32'h0};
    vt[6] = '{3'b101, 32'h0000_4003, 32'h8765_4321, 5'd11, 1'b0, 32'h0, 32'h0, 4'd0,
              32'h0000_4000, 4'b1111, 1'b1, 32'h8765_4321, 1'b0, 32'h0};
    vt[7] = '{3'b110, 32'h0000_7777, 32'hFFFF_FFFF, 5'd9, 1'b1, 32'h5555_AAAA, 32'h0, 4'd0,
              32'h0, 4'b0000, 1'b0, 32'h0, 1'b1, 32'h5555_AAAA};
    vt[8] = '{3'b001, 32'h0000_1001, 32'h0, 5'd12, 1'b1, 32'h0, 32'h0000_8000, 4'd2,
              32'h0000_1000, 4'b0010, 1'b0, 32'h0, 1'b1, 32'hFFFF_FF80};
    vt[9] = '{3'b000, 32'h0, 32'h0, 5'd3, 1'b0, 32'hFFFF_0000, 32'h0, 4'd0,
              32'h0, 4'b0000, 1'b0, 32'h0, 1'b0, 32'hFFFF_0000};

    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Table: back-to-back vectors, each memory op a full IDLE->BUSY->IDLE pass
    for (int i = 0; i < 10; i++) run_vec(vt[i]);
    flush();

    // bus_ack while IDLE must be ignored
    mem_op = 3'b000; mem_wd = 5'd12; mem_wreg = 1'b1; mem_wdata = 32'h0BAD_F00D;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    exp_q.push_back('{5'd12, 1'b1, 32'h0BAD_F00D, 1'b1});
    @(negedge clk);
    chk("stall_ack_idle", {63'd0, stallreq}, 64'd0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    pend = 1'b1;
    flush();

    // Reset in the middle of an LW, then a stale ack
    mem_op = 3'b011; mem_addr = 32'h0000_5008; mem_wd = 5'd20; mem_wreg = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pre_req", {63'd0, bus_req}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_op = 3'b000; mem_addr = 32'h0; mem_wd = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'h0;
    #1;
    chk_all_zero("rst_async");
    @(posedge clk); #1;
    rst = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("stale_stall", {63'd0, stallreq}, 64'd0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk_all_zero("stale_ack");
    @(posedge clk); #1;

`ifdef MEM_TIMEOUT_EN
    // Never acked: abort after 4 BUSY cycles
    mem_op = 3'b011; mem_addr = 32'h0000_6000; mem_wd = 5'd21; mem_wreg = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("tmo_req", {63'd0, bus_req}, 64'd1);
      chk("tmo_stall", {63'd0, stallreq}, (c < 3) ? 64'd1 : 64'd0);
      @(posedge clk); #1;
    end
    mem_op = 3'b000; mem_wd = 5'd0; mem_wreg = 1'b0;
    @(negedge clk);
    chk("tmo_drop", {63'd0, bus_req}, 64'd0);
    chk("tmo_err", {63'd0, bus_err}, 64'd1);
    chk("tmo_wreg", {63'd0, wb_wreg}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("tmo_err_pulse", {63'd0, bus_err}, 64'd0);
    @(posedge clk); #1;

    // Ack in the 4th BUSY cycle wins over the timeout
    tv = '{3'b011, 32'h0000_6004, 32'h0, 5'd22, 1'b1, 32'h0, 32'h1357_9BDF, 4'd3,
           32'h0000_6004, 4'b1111, 1'b0, 32'h0, 1'b1, 32'h1357_9BDF};
    run_vec(tv);
    flush();
`endif

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
